// File: rtl/lane_mem_sequencer_pkg.sv
// Shared types and defaults for the lane memory sequencer.
//   seq_state_t : sequencer FSM states
//   WORD_W_DEF  : default data word width
//   ADDR_W_DEF  : default DataMemory address width
package lane_mem_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int WORD_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

endpackage

// File: rtl/lane_mem_sequencer_if.sv
// Bundle of the Scheduler handshake, per-lane operands/results and the
// DataMemory port of the lane memory sequencer.
//   slave  : seen by the sequencer (takes start/operands/mem_rdata,
//            drives busy/done/lane_rdata and the memory strobes)
//   master : seen by the environment (Scheduler + DataMemory side)
interface lane_mem_sequencer_if #(
  parameter int N_CORES = 4,
  parameter int WORD_W  = lane_mem_sequencer_pkg::WORD_W_DEF,
  parameter int ADDR_W  = lane_mem_sequencer_pkg::ADDR_W_DEF
);
  logic                        start;
  logic                        op_store;
  logic [N_CORES-1:0]          lane_mask;
  logic [N_CORES*ADDR_W-1:0]   lane_addr;
  logic [N_CORES*WORD_W-1:0]   lane_wdata;
  logic                        busy;
  logic                        done;
  logic [N_CORES*WORD_W-1:0]   lane_rdata;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [WORD_W-1:0]           mem_wdata;
  logic [WORD_W-1:0]           mem_rdata;

  modport slave (
    input  start, op_store, lane_mask, lane_addr, lane_wdata, mem_rdata,
    output busy, done, lane_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output start, op_store, lane_mask, lane_addr, lane_wdata, mem_rdata,
    input  busy, done, lane_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lane_mem_sequencer_next_lane_enc.sv
// Finds the lowest set bit of a pending-lane mask strictly above a pointer.
//   pending   : lanes still waiting for their memory access
//   ptr       : current lane, one bit wider than a lane index; all-ones
//               means "before lane 0" so the same encoder yields the first lane
//   next_lane : lowest pending lane above ptr (0 when none)
//   last      : no pending lane exists above ptr
module next_lane_enc #(
  parameter int N_CORES = 4,
  parameter int PTR_W   = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic [N_CORES-1:0] pending,
  input  logic [PTR_W:0]     ptr,
  output logic [PTR_W-1:0]   next_lane,
  output logic               last
);

  int ptr_int;

  // Scan from the top down so the final hit is the lowest qualifying lane.
  always_comb begin
    ptr_int   = (&ptr) ? -1 : int'(ptr);
    next_lane = '0;
    last      = 1'b1;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (pending[i] && (i > ptr_int)) begin
        next_lane = PTR_W'(i);
        last      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lane_mem_sequencer.sv
// Sequences one SIMD load or store across the active lanes onto a
// single-port synchronous DataMemory, one lane per cycle, ascending order.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : slave modport -- start/op_store/lane_mask/lane_addr/lane_wdata in,
//           busy/done/lane_rdata out, mem_en/mem_we/mem_addr/mem_wdata out,
//           mem_rdata in (valid the cycle after a read strobe)
module lane_mem_sequencer
  import lane_mem_sequencer_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  lane_mem_sequencer_if.slave  bus
);

  localparam int PTR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  seq_state_t                state_q, state_d;
  logic                      op_store_q, op_store_d;
  logic [N_CORES-1:0]        pending_q, pending_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [N_CORES*ADDR_W-1:0] addr_q, addr_d;
  logic [N_CORES*WORD_W-1:0] wdata_q, wdata_d;
  logic [N_CORES*WORD_W-1:0] rdata_q, rdata_d;
  logic                      cap_valid_q, cap_valid_d;
  logic [PTR_W-1:0]          cap_lane_q, cap_lane_d;

  logic [N_CORES-1:0]        enc_pending;
  logic [PTR_W:0]            enc_ptr;
  logic [PTR_W-1:0]          enc_next;
  logic                      enc_last;

  // In IDLE the encoder looks at the incoming mask from "before lane 0" to
  // find the first lane; otherwise it walks the latched pending set.
  always_comb begin
    enc_pending = (state_q == IDLE) ? bus.lane_mask : pending_q;
    enc_ptr     = (state_q == IDLE) ? '1 : {1'b0, ptr_q};
  end

  next_lane_enc #(.N_CORES(N_CORES), .PTR_W(PTR_W)) u_enc (
    .pending   (enc_pending),
    .ptr       (enc_ptr),
    .next_lane (enc_next),
    .last      (enc_last)
  );

  // Next-state and memory strobes. A load's data arrives one cycle after its
  // issue, so the capture of the previous issue overlaps the current one and
  // the last load needs one extra DRAIN cycle.
  always_comb begin
    state_d       = state_q;
    op_store_d    = op_store_q;
    pending_d     = pending_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cap_valid_d   = 1'b0;
    cap_lane_d    = cap_lane_q;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;

    if (cap_valid_q) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (PTR_W'(i) == cap_lane_q) rdata_d[i*WORD_W +: WORD_W] = bus.mem_rdata;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_store_d = bus.op_store;
          pending_d  = bus.lane_mask;
          addr_d     = bus.lane_addr;
          wdata_d    = bus.lane_wdata;
          ptr_d      = enc_next;
          state_d    = enc_last ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en  = 1'b1;
        bus.mem_we  = op_store_q;
        for (int i = 0; i < N_CORES; i++) begin
          if (PTR_W'(i) == ptr_q) begin
            bus.mem_addr  = addr_q[i*ADDR_W +: ADDR_W];
            bus.mem_wdata = wdata_q[i*WORD_W +: WORD_W];
            pending_d[i]  = 1'b0;
          end
        end
        cap_valid_d = ~op_store_q;
        cap_lane_d  = ptr_q;
        if (enc_last) state_d = op_store_q ? DONE : DRAIN;
        else          ptr_d   = enc_next;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset also wipes captured lane data so an aborted
  // batch leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_store_q  <= 1'b0;
      pending_q   <= '0;
      ptr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cap_valid_q <= 1'b0;
      cap_lane_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_store_q  <= op_store_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cap_valid_q <= cap_valid_d;
      cap_lane_q  <= cap_lane_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.lane_rdata = rdata_q;

endmodule

// File: tb/tb_lane_mem_sequencer.sv
// Self-checking bench for lane_mem_sequencer: a 4-lane instance driven by a
// vector table, hand sequences and random batches against a reference model
// (shadow memory + expected lane registers), plus a 1-lane instance.
module tb_lane_mem_sequencer;

  localparam int N = 4;
  localparam int W = 16;
  localparam int A = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  lane_mem_sequencer_if #(.N_CORES(N), .WORD_W(W), .ADDR_W(A)) bus ();
  lane_mem_sequencer #(.N_CORES(N), .WORD_W(W), .ADDR_W(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  lane_mem_sequencer_if #(.N_CORES(1), .WORD_W(W), .ADDR_W(A)) bus1 ();
  lane_mem_sequencer #(.N_CORES(1), .WORD_W(W), .ADDR_W(A)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Synchronous single-port RAM seen by the 4-lane instance.
  logic [W-1:0] ram [65536];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Read-only memory for the 1-lane instance: data = addr ^ 0x1234.
  always @(posedge clk) begin
    if (bus1.mem_en && !bus1.mem_we) bus1.mem_rdata <= bus1.mem_addr ^ 16'h1234;
  end

  // Reference model state.
  logic [W-1:0] shadow [int];
  logic [W-1:0] exp_rdata [N];

  function automatic logic [W-1:0] model_read(int a);
    if (shadow.exists(a)) return shadow[a];
    return W'(a + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one batch starting at the current negedge and checks every cycle
  // until done, then the following idle cycle. noise_cyc >= 0 asserts a
  // conflicting start during that cycle, which must be ignored.
  task automatic applyStimulus(input bit op, input logic [N-1:0] mask,
                               input logic [N*A-1:0] addrs,
                               input logic [N*W-1:0] wds,
                               input int exp_done, input int noise_cyc);
    int lanes[$];
    int k;
    int acc;
    int done_cyc;
    int li;
    for (int i = 0; i < N; i++) if (mask[i]) lanes.push_back(i);
    k = lanes.size();
    bus.start      = 1'b1;
    bus.op_store   = op;
    bus.lane_mask  = mask;
    bus.lane_addr  = addrs;
    bus.lane_wdata = wds;
    acc      = 0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == noise_cyc) begin
        bus.start     = 1'b1;
        bus.op_store  = ~op;
        bus.lane_mask = '1;
      end else begin
        bus.start = 1'b0;
      end
      checkOutput("busy_in_batch", 32'(bus.busy), 32'd1);
      checkOutput("we_without_en", 32'(bus.mem_we & ~bus.mem_en), 32'd0);
      if (bus.mem_en) begin
        if (acc < k) begin
          li = lanes[acc];
          checkOutput("mem_addr", 32'(bus.mem_addr), 32'(addrs[li*A +: A]));
          checkOutput("mem_we", 32'(bus.mem_we), 32'(op));
          if (op) checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(wds[li*W +: W]));
        end
        acc++;
      end
      if (bus.done) done_cyc = cyc;
    end
    bus.start = 1'b0;
    checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
    checkOutput("access_count", 32'(acc), 32'(k));

    foreach (lanes[j]) begin
      li = lanes[j];
      if (op) shadow[int'(addrs[li*A +: A])] = wds[li*W +: W];
      else    exp_rdata[li] = model_read(int'(addrs[li*A +: A]));
    end
    for (int i = 0; i < N; i++)
      checkOutput("lane_rdata", 32'(bus.lane_rdata[i*W +: W]), 32'(exp_rdata[i]));
    if (op) begin
      foreach (lanes[j]) begin
        li = lanes[j];
        checkOutput("ram_content", 32'(ram[addrs[li*A +: A]]),
                    32'(model_read(int'(addrs[li*A +: A]))));
      end
    end

    @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_done", 32'(bus.done), 32'd0);
    checkOutput("idle_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
  endtask

  typedef struct {
    bit           op;
    logic [N-1:0] mask;
    logic [N*A-1:0] addrs;
    logic [N*W-1:0] wds;
    int           exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [N-1:0]   r_mask;
    logic [N*A-1:0] r_addr;
    logic [N*W-1:0] r_wd;
    bit             r_op;
    int             r_k;
    logic [W-1:0]   plan_rd [4];

    for (int i = 0; i < 65536; i++) ram[i] = W'(i + 1);
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    plan_rd[0] = 16'd11; plan_rd[1] = 16'd21; plan_rd[2] = 16'd31; plan_rd[3] = 16'd41;

    vecs[0] = '{1'b0, 4'b1111, {16'd40, 16'd30, 16'd20, 16'd10}, 64'h0, 5};
    vecs[1] = '{1'b1, 4'b0101, {16'd0, 16'd200, 16'd0, 16'd100},
                {16'h0, 16'h5555, 16'h0, 16'hAAAA}, 2};
    vecs[2] = '{1'b0, 4'b0101, {16'd0, 16'd200, 16'd0, 16'd100}, 64'h0, 3};
    vecs[3] = '{1'b0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, 64'h0, 0};
    vecs[4] = '{1'b1, 4'b1111, {16'd500, 16'd500, 16'd500, 16'd500},
                {16'd4, 16'd3, 16'd2, 16'd1}, 4};
    vecs[5] = '{1'b0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd500}, 64'h0, 2};
    vecs[6] = '{1'b1, 4'b0000, {16'd9, 16'd9, 16'd9, 16'd9}, 64'hFFFF, 0};

    bus.start = 1'b0; bus.op_store = 1'b0; bus.lane_mask = '0;
    bus.lane_addr = '0; bus.lane_wdata = '0;
    bus1.start = 1'b0; bus1.op_store = 1'b0; bus1.lane_mask = '0;
    bus1.lane_addr = '0; bus1.lane_wdata = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rst_lane_rdata", bus.lane_rdata[31:0], 32'd0);
    checkOutput("rst_lane_rdata_hi", bus.lane_rdata[63:32], 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Vector table, applied back to back.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].op, vecs[v].mask, vecs[v].addrs, vecs[v].wds,
                    vecs[v].exp_done, -1);
      if (v == 0)
        for (int i = 0; i < N; i++)
          checkOutput("plan_load_rdata", 32'(bus.lane_rdata[i*W +: W]), 32'(plan_rd[i]));
      if (v == 1) begin
        checkOutput("plan_ram100", 32'(ram[100]), 32'h0000AAAA);
        checkOutput("plan_ram200", 32'(ram[200]), 32'h00005555);
      end
      if (v == 4) checkOutput("plan_ram500_last_lane", 32'(ram[500]), 32'd4);
    end

    // Start during ISSUE must be ignored and not queued.
    applyStimulus(1'b0, 4'b0011, {16'd0, 16'd0, 16'd7, 16'd6}, 64'h0, 3, 1);
    applyStimulus(1'b1, 4'b1010, {16'd300, 16'd0, 16'd301, 16'd0},
                  {16'h1111, 16'h0, 16'h2222, 16'h0}, 2, 0);

    // Single-lane build: one ISSUE, one DRAIN, done in cycle 2.
    bus1.start = 1'b1; bus1.op_store = 1'b0; bus1.lane_mask = 1'b1;
    bus1.lane_addr = 16'd77;
    @(negedge clk);
    bus1.start = 1'b0;
    checkOutput("n1_c0_mem_en", 32'(bus1.mem_en), 32'd1);
    checkOutput("n1_c0_mem_addr", 32'(bus1.mem_addr), 32'd77);
    checkOutput("n1_c0_done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    checkOutput("n1_c1_mem_en", 32'(bus1.mem_en), 32'd0);
    checkOutput("n1_c1_busy", 32'(bus1.busy), 32'd1);
    checkOutput("n1_c1_done", 32'(bus1.done), 32'd0);
    @(negedge clk);
    checkOutput("n1_c2_done", 32'(bus1.done), 32'd1);
    checkOutput("n1_rdata", 32'(bus1.lane_rdata), 32'(16'd77 ^ 16'h1234));
    @(negedge clk);
    checkOutput("n1_c3_busy", 32'(bus1.busy), 32'd0);

    // Reset in cycle 2 of a 4-lane load aborts and clears everything.
    bus.start = 1'b1; bus.op_store = 1'b0; bus.lane_mask = 4'b1111;
    bus.lane_addr = {16'd3, 16'd2, 16'd1, 16'd0};
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("abort_rdata_lo", bus.lane_rdata[31:0], 32'd0);
    checkOutput("abort_rdata_hi", bus.lane_rdata[63:32], 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    @(negedge clk);
    checkOutput("post_abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_abort_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("post_abort_done", 32'(bus.done), 32'd0);
    applyStimulus(1'b0, 4'b0110, {16'd0, 16'd60, 16'd50, 16'd0}, 64'h0, 3, -1);

    // Random batches with colliding addresses, checked by the model.
    for (int r = 0; r < 30; r++) begin
      r_op   = 1'($urandom_range(0, 1));
      r_mask = N'($urandom);
      for (int i = 0; i < N; i++) begin
        r_addr[i*A +: A] = A'($urandom_range(0, 31));
        r_wd[i*W +: W]   = W'($urandom);
      end
      r_k = $countones(r_mask);
      applyStimulus(r_op, r_mask, r_addr, r_wd,
                    (r_k == 0) ? 0 : (r_op ? r_k : r_k + 1),
                    ($urandom_range(0, 3) == 0) ? 0 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
